led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Avalon-MM slave, configured by the Nios CPU, that sequences the red-LED PIO output register.
- Holds a small pattern table and replays it, one PIO write per step, each step held for a programmable dwell.
- Also forwards direct CPU LED writes, so the CPU and the sequencer share the single PIO write port without conflict.
- Sits between the CPU data master and the LED PIO s1 port. That port has no waitrequest and accepts one write per cycle.

Parameters:
- LED_WIDTH, 10, LED bits driven; upper writedata bits are zero.
- DEPTH, 16, pattern table entries; power of two, 2..256.
- DWELL_WIDTH, 32, width of the dwell counter and register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  slave register select
- chipselect  in  1  slave select
- write_n  in  1  slave write strobe, active-low
- writedata  in  32  slave write data
- readdata  out  32  combinational read mux of the selected register
- pio_address  out  2  to PIO address; always 0
- pio_chipselect  out  1  to PIO chipselect; one-cycle pulse per write
- pio_write_n  out  1  to PIO write_n; low exactly when pio_chipselect is high
- pio_writedata  out  32  to PIO writedata; zero-extended LED_WIDTH value

Behaviour:
- Reset is asynchronous and active-low on reset_n; the block uses the single clock clk.
- Reset values: all registers 0, FSM IDLE, pio_chipselect=0, pio_write_n=1, pio_writedata=0. The table is not reset.
- Registers (word address):
  - 0 CTRL (rw): bit0 RUN, bit1 LOOP.
  - 1 DWELL (rw): cycles per step; 0 is treated as 1.
  - 2 LENGTH (rw): steps, low log2(DEPTH)+1 bits; 0 or >DEPTH is clamped to DEPTH.
  - 3 MANUAL (w): LED value. Read returns the last value written to the PIO.
  - 4 TPTR (rw): table index.
  - 5 TDATA (w): table[TPTR] <= writedata[LED_WIDTH-1:0]; TPTR increments, wrapping mod DEPTH. Read returns table[TPTR].
  - 6 STATUS: bits[7:0] current step, bit8 BUSY, bit9 DONE (sticky, W1C), bit10 DROP (sticky, W1C).
  - 7 reads 0.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE -> ISSUE: on the cycle after RUN goes 0->1. Step is set to 0.
  - ISSUE: one cycle. Pulses the PIO write with table[step] and loads the dwell counter with DWELL-1.
  - ISSUE -> HOLD.
  - HOLD: the counter decrements each cycle. At 0:
    - step < LENGTH-1: step++, go to ISSUE.
    - else if LOOP=1: step=0, go to ISSUE.
    - else: clear RUN, set DONE, go to IDLE.
- Step spacing is exactly max(DWELL,1)+1 cycles between consecutive PIO write pulses.
- Writing RUN=0 while BUSY aborts the sequence: next state is IDLE, no further PIO writes, LEDs hold their last value, DONE is not set.
- Writing RUN=1 while already BUSY has no effect.
- MANUAL write while IDLE: PIO write pulse on the next cycle with that value.
- MANUAL write while BUSY: the value is discarded and DROP is set.
- The sequencer and a MANUAL write are never pulsed in the same cycle.
- DWELL or LENGTH changed while BUSY takes effect at the next counter load or step decision.
- Table writes while BUSY are allowed and affect later steps.
- BUSY = (state != IDLE).
- reset_n low mid-sequence returns to reset values immediately; no partial PIO write pulse may be emitted.

Optional Feature:
- Macro LED_SEQ_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered, resets 0) and CTRL bit2 IRQEN.
  - irq = IRQEN & DONE; it clears when DONE is cleared via W1C.
- Undefined:
  - No irq port; CTRL bit2 reads 0 and ignores writes.

Test Plan:
- Reset, then read all registers -> all 0; pio_chipselect=0 and pio_write_n=1 throughout.
- Load table 0x001,0x002,0x004; LENGTH=3, DWELL=4; write CTRL=1 -> PIO writes 0x001,0x002,0x004 spaced 5 cycles apart; then DONE=1, RUN=0, BUSY=0, LEDs stay 0x004.
- Same setup with LOOP=1 -> writes 0x001,0x002,0x004,0x001 spaced 5 cycles; write CTRL=0 during HOLD -> no further pulses, DONE=0.
- DWELL=0 and LENGTH=2 -> pulses 2 cycles apart. Write TPTR=15, then two TDATA writes -> TPTR wraps to 1.
- MANUAL=0x3FF while IDLE -> one pulse carrying 0x3FF. MANUAL=0x155 while BUSY -> no pulse, DROP=1; W1C of STATUS bit10 -> DROP=0.
- With LED_SEQ_IRQ_EN defined and IRQEN=1: irq rises after the final step, and falls after writing 0x200 to STATUS. Assert reset_n mid-HOLD -> outputs return to reset values and irq=0.

Source files
------------

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM slave bus between the CPU data master and the LED pattern sequencer.
interface led_pattern_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Replays a small LED pattern table into the red-LED PIO and forwards direct CPU LED writes.
// Optional macro LED_SEQ_IRQ_EN adds the irq output and the CTRL.IRQEN bit.
module led_pattern_sequencer #(
  parameter int LED_WIDTH   = 10,
  parameter int DEPTH       = 16,
  parameter int DWELL_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  led_pattern_sequencer_if.slave bus,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
`ifdef LED_SEQ_IRQ_EN
  output logic                  irq,
`endif
  output logic [31:0]           pio_writedata
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_run, r_loop, r_done, r_drop;
  logic [DWELL_WIDTH-1:0] r_dwell, r_cnt;
  logic [LW-1:0]          r_length;
  logic [AW-1:0]          r_tptr, r_step;
  logic                   r_pio_cs;
  logic [LED_WIDTH-1:0]   r_pio_data;
  logic [LED_WIDTH-1:0]   r_table [DEPTH];
  logic                   w_irqen;

  logic w_wr, w_busy, w_ctrl_clr, w_abort, w_man;
  logic w_issue, w_step_inc, w_step_zero, w_finish, w_more;
  logic [LW-1:0]          w_len_eff;
  logic [DWELL_WIDTH-1:0] w_load;
  logic                   w_unused;

  assign w_wr       = bus.chipselect & ~bus.write_n;
  assign w_busy     = (r_state != IDLE);
  assign w_ctrl_clr = w_wr && (bus.address == 3'd0) && !bus.writedata[0];
  assign w_abort    = w_ctrl_clr & w_busy;
  assign w_man      = w_wr && (bus.address == 3'd3);
  assign w_unused   = &{1'b0, bus.writedata};

  assign w_len_eff = (r_length == '0 || r_length > LW'(DEPTH)) ? LW'(DEPTH) : r_length;
  assign w_more    = ({1'b0, r_step} < (w_len_eff - LW'(1)));
  assign w_load    = (r_dwell == '0) ? '0 : r_dwell - DWELL_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_step_inc  = 1'b0;
    w_step_zero = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (r_run && !w_ctrl_clr) begin
        w_state_nxt = ISSUE;
        w_step_zero = 1'b1;
      end
      ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = HOLD;
      end
      HOLD: if (r_cnt == '0) begin
        if (w_more) begin
          w_step_inc  = 1'b1;
          w_state_nxt = ISSUE;
        end else if (r_loop) begin
          w_step_zero = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // An abort suppresses the pending pulse and the DONE flag in the same cycle.
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_issue     = 1'b0;
      w_finish    = 1'b0;
      w_step_inc  = 1'b0;
      w_step_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && bus.address == 3'd5) r_table[r_tptr] <= bus.writedata[LED_WIDTH-1:0];
  end

`ifdef LED_SEQ_IRQ_EN
  logic r_irqen, r_irq;
  assign w_irqen = r_irqen;
  assign irq     = r_irq;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqen <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr && bus.address == 3'd0) r_irqen <= bus.writedata[2];
      r_irq <= r_irqen & r_done;
    end
  end
`else
  assign w_irqen = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= 1'b0;
      r_loop     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_dwell    <= '0;
      r_cnt      <= '0;
      r_length   <= '0;
      r_tptr     <= '0;
      r_step     <= '0;
      r_pio_cs   <= 1'b0;
      r_pio_data <= '0;
    end else begin
      if (w_wr) begin
        case (bus.address)
          3'd0: begin
            r_run  <= bus.writedata[0];
            r_loop <= bus.writedata[1];
          end
          3'd1: r_dwell  <= bus.writedata[DWELL_WIDTH-1:0];
          3'd2: r_length <= bus.writedata[LW-1:0];
          3'd4: r_tptr   <= bus.writedata[AW-1:0];
          3'd5: r_tptr   <= r_tptr + AW'(1);
          default: ;
        endcase
      end
      if (w_finish) r_run <= 1'b0;

      if (w_finish)                                                 r_done <= 1'b1;
      else if (w_wr && bus.address == 3'd6 && bus.writedata[9])     r_done <= 1'b0;
      if (w_man && w_busy)                                          r_drop <= 1'b1;
      else if (w_wr && bus.address == 3'd6 && bus.writedata[10])    r_drop <= 1'b0;

      if (w_step_zero)     r_step <= '0;
      else if (w_step_inc) r_step <= r_step + AW'(1);

      if (r_state == ISSUE)                    r_cnt <= w_load;
      else if (r_state == HOLD && r_cnt != '0) r_cnt <= r_cnt - DWELL_WIDTH'(1);

      // Manual writes only land while idle, so they never collide with a sequencer pulse.
      r_pio_cs <= 1'b0;
      if (w_issue) begin
        r_pio_cs   <= 1'b1;
        r_pio_data <= r_table[r_step];
      end else if (w_man && !w_busy) begin
        r_pio_cs   <= 1'b1;
        r_pio_data <= bus.writedata[LED_WIDTH-1:0];
      end
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = r_pio_cs;
  assign pio_write_n    = ~r_pio_cs;
  assign pio_writedata  = 32'(r_pio_data);

  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      3'd0: bus.readdata = {29'h0, w_irqen, r_loop, r_run};
      3'd1: bus.readdata = 32'(r_dwell);
      3'd2: bus.readdata = 32'(r_length);
      3'd3: bus.readdata = 32'(r_pio_data);
      3'd4: bus.readdata = 32'(r_tptr);
      3'd5: bus.readdata = 32'(r_table[r_tptr]);
      3'd6: bus.readdata = {21'h0, r_drop, r_done, w_busy, 8'(r_step)};
      default: bus.readdata = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: expected PIO writes are queued with their spacing.
module tb_led_pattern_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  led_pattern_sequencer_if bus();
  logic [1:0]  pio_address;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  led_pattern_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
`ifdef LED_SEQ_IRQ_EN
    .irq            (irq),
`endif
    .pio_writedata  (pio_writedata)
  );

  typedef struct {logic [31:0] data; int gap;} exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0, cyc = 0, last_cyc = 0;
  logic [31:0] rd;

  always @(posedge clk) cyc++;

  // PIO monitor: every pulse must match the head of the scoreboard, including its spacing.
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (pio_write_n !== ~pio_chipselect) begin
      $display("FAIL pio_write_n got=%b cs=%b", pio_write_n, pio_chipselect); n_err++;
    end
    if (pio_chipselect === 1'b1) begin
      n_cmp++;
      if (pio_address !== 2'b00) begin
        $display("FAIL pio_address got=%h exp=0", pio_address); n_err++;
      end
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse data=%h cyc=%0d", pio_writedata, cyc); n_err++;
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (pio_writedata !== e.data) begin
          $display("FAIL pulse_data got=%h exp=%h", pio_writedata, e.data); n_err++;
        end
        if (e.gap != 0) begin
          n_cmp++;
          if (cyc - last_cyc != e.gap) begin
            $display("FAIL pulse_gap got=%0d exp=%0d", cyc - last_cyc, e.gap); n_err++;
          end
        end
      end
      last_cyc = cyc;
    end
  end

  function automatic void push(input logic [31:0] d, input int gap);
    exp_t e;
    e.data = d; e.gap = gap;
    sb.push_back(e);
  endfunction

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    #1 d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic wait_drain(input int max, input string nm);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      @(posedge clk); k++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      $display("FAIL %s_timeout pending=%0d exp=0", nm, sb.size()); n_err++;
      sb.delete();
    end
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #3;
    n_cmp++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0) begin
      $display("FAIL reset_outputs got=%b/%b/%h exp=0/1/0", pio_chipselect, pio_write_n, pio_writedata);
      n_err++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // TDATA is skipped: the table has no reset.
    for (int a = 0; a < 8; a++) begin
      if (a != 5) begin
        cpu_rd(3'(a), rd);
        n_cmp++;
        if (rd !== 32'h0) begin
          $display("FAIL reset_reg%0d got=%h exp=0", a, rd); n_err++;
        end
      end
    end
  endtask

  task automatic test_single;
    cpu_wr(3'd4, 0);
    cpu_wr(3'd5, 32'h001); cpu_wr(3'd5, 32'h002); cpu_wr(3'd5, 32'h004);
    cpu_wr(3'd2, 3); cpu_wr(3'd1, 4);
    push(32'h001, 0); push(32'h002, 5); push(32'h004, 5);
    cpu_wr(3'd0, 1);
    wait_drain(100, "single");
    repeat (8) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if ((rd & 32'h700) !== 32'h200) begin
      $display("FAIL single_status got=%h exp=200", rd & 32'h700); n_err++;
    end
    cpu_rd(3'd0, rd); n_cmp++;
    if (rd !== 32'h0) begin $display("FAIL single_ctrl got=%h exp=0", rd); n_err++; end
    cpu_rd(3'd3, rd); n_cmp++;
    if (rd !== 32'h004) begin $display("FAIL single_leds got=%h exp=004", rd); n_err++; end
  endtask

  task automatic test_loop_abort;
    cpu_wr(3'd6, 32'h200);
    push(32'h001, 0); push(32'h002, 5); push(32'h004, 5); push(32'h001, 5);
    cpu_wr(3'd0, 3);
    wait_drain(100, "loop");
    cpu_wr(3'd0, 0);
    repeat (20) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if ((rd & 32'h700) !== 32'h0) begin
      $display("FAIL abort_status got=%h exp=0", rd & 32'h700); n_err++;
    end
    cpu_rd(3'd3, rd); n_cmp++;
    if (rd !== 32'h001) begin $display("FAIL abort_leds got=%h exp=001", rd); n_err++; end
  endtask

  task automatic test_dwell0_wrap;
    cpu_wr(3'd1, 0); cpu_wr(3'd2, 2);
    cpu_wr(3'd4, 15); cpu_wr(3'd5, 32'h0AA); cpu_wr(3'd5, 32'h055);
    cpu_rd(3'd4, rd); n_cmp++;
    if (rd !== 32'd1) begin $display("FAIL tptr_wrap got=%0d exp=1", rd); n_err++; end
    cpu_rd(3'd5, rd); n_cmp++;
    if (rd !== 32'h002) begin $display("FAIL tdata_read got=%h exp=002", rd); n_err++; end
    push(32'h055, 0); push(32'h002, 2);
    cpu_wr(3'd0, 1);
    wait_drain(50, "dwell0");
    repeat (6) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if ((rd & 32'h700) !== 32'h200) begin
      $display("FAIL dwell0_status got=%h exp=200", rd & 32'h700); n_err++;
    end
  endtask

  task automatic test_manual;
    cpu_wr(3'd6, 32'h600);
    push(32'h3FF, 0);
    cpu_wr(3'd3, 32'h3FF);
    wait_drain(10, "manual_idle");
    cpu_rd(3'd3, rd); n_cmp++;
    if (rd !== 32'h3FF) begin $display("FAIL manual_read got=%h exp=3ff", rd); n_err++; end
    cpu_wr(3'd2, 3); cpu_wr(3'd1, 4);
    push(32'h055, 0); push(32'h002, 5); push(32'h004, 5);
    cpu_wr(3'd0, 1);
    repeat (3) @(posedge clk);
    cpu_wr(3'd3, 32'h155);
    wait_drain(100, "manual_busy");
    repeat (8) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if ((rd & 32'h700) !== 32'h600) begin
      $display("FAIL drop_set got=%h exp=600", rd & 32'h700); n_err++;
    end
    cpu_wr(3'd6, 32'h400);
    cpu_rd(3'd6, rd); n_cmp++;
    if ((rd & 32'h700) !== 32'h200) begin
      $display("FAIL drop_clear got=%h exp=200", rd & 32'h700); n_err++;
    end
    cpu_rd(3'd3, rd); n_cmp++;
    if (rd !== 32'h004) begin $display("FAIL drop_leds got=%h exp=004", rd); n_err++; end
  endtask

  task automatic test_length_clamp;
    logic [31:0] v;
    cpu_wr(3'd6, 32'h600);
    cpu_wr(3'd4, 0);
    for (int i = 0; i < 16; i++) cpu_wr(3'd5, (i * 37 + 1) & 32'h3FF);
    cpu_wr(3'd2, 17); cpu_wr(3'd1, 1);
    cpu_rd(3'd2, rd); n_cmp++;
    if (rd !== 32'd17) begin $display("FAIL length_read got=%0d exp=17", rd); n_err++; end
    for (int i = 0; i < 16; i++) begin
      v = (i * 37 + 1) & 32'h3FF;
      push(v, (i == 0) ? 0 : 2);
    end
    cpu_wr(3'd0, 1);
    wait_drain(200, "clamp");
    repeat (6) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if (rd[10:0] !== 11'h20F) begin
      $display("FAIL clamp_status got=%h exp=20f", rd[10:0]); n_err++;
    end
  endtask

`ifdef LED_SEQ_IRQ_EN
  task automatic test_irq;
    cpu_wr(3'd6, 32'h600);
    cpu_wr(3'd2, 1); cpu_wr(3'd1, 2);
    push(32'h001, 0);
    cpu_wr(3'd0, 5);
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL irq_early got=%b exp=0", irq); n_err++; end
    wait_drain(50, "irq");
    repeat (6) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b1) begin $display("FAIL irq_rise got=%b exp=1", irq); n_err++; end
    cpu_rd(3'd0, rd); n_cmp++;
    if (rd !== 32'h4) begin $display("FAIL irq_ctrl got=%h exp=4", rd); n_err++; end
    cpu_wr(3'd6, 32'h200);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL irq_fall got=%b exp=0", irq); n_err++; end
  endtask
`endif

  task automatic test_reset_mid;
    cpu_wr(3'd6, 32'h600);
    cpu_wr(3'd2, 2); cpu_wr(3'd1, 20);
    push(32'h001, 0);
    cpu_wr(3'd0, 1);
    wait_drain(50, "midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0) begin
      $display("FAIL midrst_outputs got=%b/%b/%h exp=0/1/0", pio_chipselect, pio_write_n, pio_writedata);
      n_err++;
    end
`ifdef LED_SEQ_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin $display("FAIL midrst_irq got=%b exp=0", irq); n_err++; end
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    cpu_rd(3'd6, rd); n_cmp++;
    if (rd !== 32'h0) begin $display("FAIL midrst_status got=%h exp=0", rd); n_err++; end
    cpu_rd(3'd1, rd); n_cmp++;
    if (rd !== 32'h0) begin $display("FAIL midrst_dwell got=%h exp=0", rd); n_err++; end
  endtask

  initial begin
    bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
    test_reset();
    test_single();
    test_loop_abort();
    test_dwell0_wrap();
    test_manual();
    test_length_clamp();
`ifdef LED_SEQ_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin $display("FAIL leftover got=%0d exp=0", sb.size()); n_err++; end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
